imem_loader: RTL and testbench

- Byte-stream program loader: the write side of the instruction memory.
- Accepts a framed byte stream (valid/ready) from a host link such as a UART receiver.
- Assembles little-endian 32-bit words, writes them into instruction memory, and verifies a trailing checksum.
- Holds the CPU in reset while loading; releases it only after a successful load.

---
 rtl/imem_loader_pkg.sv | 21 ++
 rtl/imem_loader_if.sv | 26 ++
 rtl/imem_loader_packer.sv | 44 ++++
 rtl/imem_loader.sv | 130 +++++++++++++
 tb/tb_imem_loader.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    CHECK,
    DONE,
    ERR
  } state_t;

  localparam int HDR_LEN    = 4;
  localparam int WORD_BYTES = 4;
  localparam int CSUM_W     = 8;

  function automatic logic [31:0] max_words(input int mem_bytes);
    return 32'(mem_bytes / WORD_BYTES);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Loader bus: byte stream in, memory word writes and CPU control out.
interface imem_loader_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 8
);
  logic                     start;
  logic                     in_valid;
  logic [DATA_WIDTH-1:0]    in_data;
  logic                     in_ready;
  logic                     wr_en;
  logic [ADDRESS_WIDTH-1:0] wr_addr;
  logic [31:0]              wr_data;
  logic                     cpu_hold;
  logic                     done;
  logic                     error;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error
  );
endinterface

// File: rtl/imem_loader_packer.sv
// Packs accepted bytes little-endian into 32-bit words; emits a one-cycle
// word-valid pulse the cycle after the 4th byte when i_emit is set.
module byte_to_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_vld,
  input  logic        i_emit,
  input  logic [7:0]  i_dat,
  output logic [31:0] o_word,
  output logic        o_word_vld,
  output logic [31:0] o_next_word,
  output logic        o_last
);

  logic [1:0]  r_lane;
  logic [31:0] r_word;
  logic        r_word_vld;

  // Newest byte enters at the top, so after 4 shifts byte 0 sits in [7:0].
  assign o_next_word = {i_dat, r_word[31:8]};
  assign o_last      = i_vld && (r_lane == 2'(WORD_BYTES - 1));
  assign o_word      = r_word;
  assign o_word_vld  = r_word_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lane     <= 2'd0;
      r_word     <= 32'd0;
      r_word_vld <= 1'b0;
    end else begin
      r_word_vld <= i_emit && o_last && !i_clr;
      if (i_clr) begin
        r_lane <= 2'd0;
      end else if (i_vld) begin
        r_word <= o_next_word;
        r_lane <= r_lane + 2'd1;
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader: length header, data words written to imem,
// trailing additive checksum; holds the CPU in reset until a good load.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 8,
  parameter int MEM_BYTES     = 1024
) (
  input  logic         clk,
  input  logic         rst,
  imem_loader_if.slave bus
);

  localparam logic [31:0] MAX_WORDS = max_words(MEM_BYTES);

  state_t                   r_state;
  logic                     r_in_ready;
  logic                     r_cpu_hold;
  logic                     r_done;
  logic                     r_error;
  logic [31:0]              r_len;
  logic [31:0]              r_word_idx;
  logic [CSUM_W-1:0]        r_sum;
  logic [ADDRESS_WIDTH-1:0] r_wr_addr;

  logic [DATA_WIDTH-1:0]    w_byte;
  logic                     w_acc;
  logic                     w_restart;
  logic [31:0]              w_word;
  logic                     w_word_vld;
  logic [31:0]              w_next_word;
  logic                     w_last;
  logic [ADDRESS_WIDTH-1:0] w_addr;

  assign w_byte    = bus.in_data;
  assign w_acc     = bus.in_valid && r_in_ready;
  assign w_restart = bus.start && (r_state == IDLE || r_state == DONE || r_state == ERR);
  assign w_addr    = ADDRESS_WIDTH'({r_word_idx[29:0], 2'b00});

  byte_to_word_packer u_packer (
    .clk         (clk),
    .rst         (rst),
    .i_clr       (w_restart),
    .i_vld       (w_acc && (r_state == LEN || r_state == DATA)),
    .i_emit      (r_state == DATA),
    .i_dat       (w_byte[7:0]),
    .o_word      (w_word),
    .o_word_vld  (w_word_vld),
    .o_next_word (w_next_word),
    .o_last      (w_last)
  );

  assign bus.in_ready = r_in_ready;
  assign bus.wr_en    = w_word_vld;
  assign bus.wr_addr  = r_wr_addr;
  assign bus.wr_data  = w_word;
  assign bus.cpu_hold = r_cpu_hold;
  assign bus.done     = r_done;
  assign bus.error    = r_error;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_in_ready <= 1'b0;
      r_cpu_hold <= 1'b1;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_len      <= 32'd0;
      r_word_idx <= 32'd0;
      r_sum      <= '0;
      r_wr_addr  <= '0;
    end else begin
      case (r_state)
        IDLE, DONE, ERR: begin
          if (bus.start) begin
            r_state    <= LEN;
            r_in_ready <= 1'b1;
            r_cpu_hold <= 1'b1;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_len      <= 32'd0;
            r_word_idx <= 32'd0;
            r_sum      <= '0;
          end
        end
        LEN: begin
          // Length is judged on the combinational word so no extra byte slips in.
          if (w_acc && w_last) begin
            r_len <= w_next_word;
            if (w_next_word > MAX_WORDS) begin
              r_state    <= ERR;
              r_in_ready <= 1'b0;
              r_error    <= 1'b1;
            end else if (w_next_word == 32'd0) begin
              r_state <= CHECK;
            end else begin
              r_state <= DATA;
            end
          end
        end
        DATA: begin
          if (w_acc) begin
            r_sum <= r_sum + CSUM_W'(w_byte);
            if (w_last) begin
              r_wr_addr  <= w_addr;
              r_word_idx <= r_word_idx + 32'd1;
              if (r_word_idx + 32'd1 == r_len) r_state <= CHECK;
            end
          end
        end
        CHECK: begin
          if (w_acc) begin
            r_in_ready <= 1'b0;
            if (CSUM_W'(w_byte) == r_sum) begin
              r_state    <= DONE;
              r_done     <= 1'b1;
              r_cpu_hold <= 1'b0;
            end else begin
              r_state <= ERR;
              r_error <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized loads against a frame-level reference model.
module tb_imem_loader;

  localparam int MEM_BYTES = 1024;
  localparam int MAXW      = MEM_BYTES / 4;
  localparam int LIMIT     = 300;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(8)) bus();

  imem_loader #(.ADDRESS_WIDTH(32), .DATA_WIDTH(8), .MEM_BYTES(MEM_BYTES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total    = 0;
  int bad      = 0;
  int wr_count = 0;

  always @(negedge clk) if (bus.wr_en === 1'b1) wr_count++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bq_t rand_data(input int n);
    bq_t d;
    for (int i = 0; i < 4 * n; i++) d.push_back(8'($urandom));
    return d;
  endfunction

  // Reference frame: LE length, data, then sum of data bytes mod 256.
  function automatic bq_t mk_frame(input int n, input bq_t data, input bit corrupt);
    bq_t f;
    logic [31:0] nn;
    int s;
    nn = 32'(n);
    s  = 0;
    for (int i = 0; i < 4; i++) f.push_back(nn[8*i +: 8]);
    foreach (data[i]) begin
      f.push_back(data[i]);
      s = s + int'(data[i]);
    end
    if (corrupt) s = s + 1;
    f.push_back(8'(s % 256));
    return f;
  endfunction

  task automatic send(input bq_t q, input int gap, input bit poke);
    int n;
    bit pend;
    int pw;
    bit ph;
    n    = (q.size() >= 4) ? int'({q[3], q[2], q[1], q[0]}) : 0;
    pend = 1'b0;
    pw   = 0;
    ph   = 1'b0;
    for (int p = 0; p < q.size(); p++) begin
      bit accepted;
      int budget;
      accepted = 1'b0;
      budget   = 0;
      while (!accepted) begin
        bit idle;
        @(negedge clk);
        if (pend) begin
          logic [31:0] ew;
          ew = {q[4+4*pw+3], q[4+4*pw+2], q[4+4*pw+1], q[4+4*pw]};
          chk($sformatf("wr_en w%0d", pw), 64'(bus.wr_en), 64'd1);
          chk($sformatf("wr_addr w%0d", pw), 64'(bus.wr_addr), 64'(4 * pw));
          chk($sformatf("wr_data w%0d", pw), 64'(bus.wr_data), 64'(ew));
          pend = 1'b0;
        end
        total++;
        assert (budget < LIMIT) else begin
          bad++;
          $error("FAIL accept_timeout: byte %0d waited=%0d limit=%0d", p, budget, LIMIT);
          bus.in_valid = 1'b0;
          bus.start    = 1'b0;
          return;
        end
        total--;
        idle = (gap == 1) ? ph : (gap == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
        ph   = !ph;
        budget++;
        if (idle) begin
          bus.in_valid = 1'b0;
          bus.start    = 1'b0;
        end else begin
          bus.in_valid = 1'b1;
          bus.in_data  = q[p];
          bus.start    = poke && (p == 5);
          accepted     = bus.in_ready;
        end
      end
      if (p >= 4 && n <= MAXW && p < 4 + 4 * n && ((p - 4) % 4) == 3) begin
        pend = 1'b1;
        pw   = (p - 4) / 4;
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    if (pend) begin
      chk("wr_en last", 64'(bus.wr_en), 64'd1);
      chk("wr_addr last", 64'(bus.wr_addr), 64'(4 * pw));
      chk("wr_data last", 64'(bus.wr_data),
          64'({q[4+4*pw+3], q[4+4*pw+2], q[4+4*pw+1], q[4+4*pw]}));
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " in_ready"}, 64'(bus.in_ready), 64'd0);
    chk({tag, " wr_en"},    64'(bus.wr_en),    64'd0);
    chk({tag, " wr_addr"},  64'(bus.wr_addr),  64'd0);
    chk({tag, " wr_data"},  64'(bus.wr_data),  64'd0);
    chk({tag, " cpu_hold"}, 64'(bus.cpu_hold), 64'd1);
    chk({tag, " done"},     64'(bus.done),     64'd0);
    chk({tag, " error"},    64'(bus.error),    64'd0);
  endtask

  task automatic check_end(input string tag, input bit ok, input int nwr, input int base);
    @(negedge clk);
    chk({tag, " done"},     64'(bus.done),     64'(ok));
    chk({tag, " error"},    64'(bus.error),    64'(!ok));
    chk({tag, " cpu_hold"}, 64'(bus.cpu_hold), 64'(!ok));
    chk({tag, " in_ready"}, 64'(bus.in_ready), 64'd0);
    chk({tag, " writes"},   64'(wr_count - base), 64'(nwr));
  endtask

  task automatic run_load(input string tag, input bq_t data, input int gap,
                          input bit corrupt, input bit poke);
    bq_t f;
    int  base;
    int  n;
    n    = data.size() / 4;
    f    = mk_frame(n, data, corrupt);
    base = wr_count;
    pulse_start();
    send(f, gap, poke);
    check_end(tag, !corrupt, n, base);
  endtask

  initial begin
    bq_t d;
    bq_t f;
    int  base;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle in_ready", 64'(bus.in_ready), 64'd0);

    // 7-word program, continuous valid
    d = '{8'h13, 8'h03, 8'hf0, 8'h0f, 8'h13, 8'h05, 8'h00, 8'h00};
    d = {d, rand_data(5)};
    run_load("prog7", d, 0, 1'b0, 1'b0);

    // Single word with in_valid toggling
    run_load("stall", '{8'h13, 8'h00, 8'h00, 8'h00}, 1, 1'b0, 1'b0);

    // Bad checksum still writes, then errors
    run_load("badsum", '{8'h13, 8'h00, 8'h00, 8'h00}, 0, 1'b1, 1'b0);

    // Overflow: 257 words
    base = wr_count;
    pulse_start();
    send('{8'h01, 8'h01, 8'h00, 8'h00}, 0, 1'b0);
    check_end("ovf", 1'b0, 0, base);

    // Zero length, then restart
    base = wr_count;
    pulse_start();
    send('{8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 1'b0);
    check_end("zero", 1'b1, 0, base);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("restart done", 64'(bus.done), 64'd0);
    chk("restart cpu_hold", 64'(bus.cpu_hold), 64'd1);
    chk("restart in_ready", 64'(bus.in_ready), 64'd1);
    d    = rand_data(3);
    f    = mk_frame(3, d, 1'b0);
    base = wr_count;
    send(f, 2, 1'b0);
    check_end("restart load", 1'b1, 3, base);

    // Reset after 6 data bytes
    pulse_start();
    d = rand_data(3);
    f = mk_frame(3, d, 1'b0);
    f = f[0:9];
    send(f, 0, 1'b0);
    rst = 1'b1;
    #1;
    check_reset("midrst");
    @(negedge clk);
    rst = 1'b0;
    run_load("post_rst", rand_data(3), 0, 1'b0, 1'b0);

    // Maximum length fills the whole memory
    run_load("max", rand_data(MAXW), 0, 1'b0, 1'b0);

    // Randomized loads; one with a start pulse mid-data
    for (int k = 0; k < 6; k++) begin
      run_load($sformatf("rnd%0d", k), rand_data($urandom_range(1, 12)),
               $urandom_range(0, 2), ($urandom_range(0, 2) == 0), (k == 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
